// File: rtl/fft_twiddle_seq.sv
// rtl/fft_twiddle_seq.sv - twiddle scheduler for one radix-2 DIF SDF stage of a 64-point FFT
// Tags each sample with its octant-reduced twiddle control word, one output register deep.
module fft_twiddle_seq #(
    parameter int LENGTH = 14,
    parameter int STAGE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_re,
    input  logic [LENGTH-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_re,
    output logic [LENGTH-1:0] out_im,
    output logic              tw_bypass,
    output logic [2:0]        tw_sel,
    output logic [2:0]        tw_oct,
    output logic              tw_mirror,
    output logic [5:0]        out_idx,
    output logic              frame_first,
    output logic              frame_last
);

    localparam int SPAN = 64 >> STAGE;
    localparam logic [5:0] IDX_MASK = 6'(SPAN - 1);
    localparam logic [5:0] HALF     = 6'(SPAN / 2);

    logic [5:0] n_q;
    logic [5:0] m;
    logic [5:0] k;
    logic [2:0] oct;
    logic [2:0] rem;
    logic       bypass_d;
    logic [2:0] sel_d;
    logic       accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Lower butterfly leg gets exponent (m-h)<<STAGE; upper leg is untwiddled.
    always_comb begin
        m = n_q & IDX_MASK;
        k = 6'd0;
        if (m >= HALF) begin
            k = (m - HALF) << STAGE;
        end
    end

    // Odd octants mirror the residual angle so only k'=1..8 constants are needed.
    always_comb begin
        oct      = k[5:3];
        rem      = k[2:0];
        bypass_d = 1'b0;
        sel_d    = 3'd0;
        if (oct[0]) begin
            sel_d = 3'd7 - rem;
        end else if (rem == 3'd0) begin
            bypass_d = 1'b1;
        end else begin
            sel_d = rem - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 6'd0;
        end else if (frame_clr) begin
            n_q <= 6'd0;
        end else if (accept) begin
            n_q <= n_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            tw_bypass   <= 1'b0;
            tw_sel      <= 3'd0;
            tw_oct      <= 3'd0;
            tw_mirror   <= 1'b0;
            out_idx     <= 6'd0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_re      <= in_re;
            out_im      <= in_im;
            tw_bypass   <= bypass_d;
            tw_sel      <= sel_d;
            tw_oct      <= oct;
            tw_mirror   <= oct[0];
            out_idx     <= n_q;
            frame_first <= (n_q == 6'd0);
            frame_last  <= (n_q == 6'd63);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// tb/tb_fft_twiddle_seq.sv - directed self-checking bench for fft_twiddle_seq (STAGE 0 and 2)
module tb_fft_twiddle_seq;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;

    logic         in_ready0, out_valid0, tw_bypass0, tw_mirror0, ff0, fl0;
    logic [W-1:0] out_re0, out_im0;
    logic [2:0]   tw_sel0, tw_oct0;
    logic [5:0]   out_idx0;

    logic         in_ready2, out_valid2, tw_bypass2, tw_mirror2, ff2, fl2;
    logic [W-1:0] out_re2, out_im2;
    logic [2:0]   tw_sel2, tw_oct2;
    logic [5:0]   out_idx2;

    logic [7:0]   ctrl0, ctrl2;
    assign ctrl0 = {tw_bypass0, tw_sel0, tw_oct0, tw_mirror0};
    assign ctrl2 = {tw_bypass2, tw_sel2, tw_oct2, tw_mirror2};

    int checks = 0;
    int passed = 0;

    fft_twiddle_seq #(.LENGTH(W), .STAGE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr),
        .in_valid(in_valid), .in_ready(in_ready0), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0),
        .tw_bypass(tw_bypass0), .tw_sel(tw_sel0), .tw_oct(tw_oct0), .tw_mirror(tw_mirror0),
        .out_idx(out_idx0), .frame_first(ff0), .frame_last(fl0)
    );

    fft_twiddle_seq #(.LENGTH(W), .STAGE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr),
        .in_valid(in_valid), .in_ready(in_ready2), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid2), .out_ready(out_ready), .out_re(out_re2), .out_im(out_im2),
        .tw_bypass(tw_bypass2), .tw_sel(tw_sel2), .tw_oct(tw_oct2), .tw_mirror(tw_mirror2),
        .out_idx(out_idx2), .frame_first(ff2), .frame_last(fl2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid0); else passed++;
        checks++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready0); else passed++;
        checks++; if (ctrl0 !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", ctrl0); else passed++;
        checks++; if ({out_idx0, ff0, fl0} !== 8'h00) $display("FAIL reset_idx_flags: got %h expected 00", {out_idx0, ff0, fl0}); else passed++;
        checks++; if ({out_re0, out_im0} !== '0) $display("FAIL reset_data: got %h expected 0", {out_re0, out_im0}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_stage_frame();
        logic [7:0] exp0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            in_re = W'(n);
            in_im = ~W'(n);
            step();
            checks++;
            if (out_idx0 !== 6'(n) || out_re0 !== W'(n) || out_valid0 !== 1'b1)
                $display("FAIL frame_idx: got idx %0d re %0d v %0b expected idx %0d re %0d v 1", out_idx0, out_re0, out_valid0, n, n);
            else passed++;
            exp0 = 8'hxx;
            case (n)
                5:  exp0 = {1'b1, 3'd0, 3'd0, 1'b0};
                33: exp0 = {1'b0, 3'd0, 3'd0, 1'b0};
                40: exp0 = {1'b0, 3'd7, 3'd1, 1'b1};
                48: exp0 = {1'b1, 3'd0, 3'd2, 1'b0};
                63: exp0 = {1'b0, 3'd0, 3'd3, 1'b1};
                default: ;
            endcase
            if (n == 5 || n == 33 || n == 40 || n == 48 || n == 63) begin
                checks++;
                if (ctrl0 !== exp0) $display("FAIL stage0_ctrl_n%0d: got %h expected %h", n, ctrl0, exp0); else passed++;
            end
            if (n == 63) begin
                checks++;
                if ({ff0, fl0} !== 2'b01) $display("FAIL frame_last: got %b expected 01", {ff0, fl0}); else passed++;
            end
            if (n == 13) begin
                checks++;
                if (ctrl2 !== {1'b0, 3'd3, 3'd2, 1'b0}) $display("FAIL stage2_ctrl_n13: got %h expected %h", ctrl2, {1'b0, 3'd3, 3'd2, 1'b0}); else passed++;
            end
            if (n == 7) begin
                checks++;
                if (ctrl2 !== {1'b1, 3'd0, 3'd0, 1'b0}) $display("FAIL stage2_ctrl_n7: got %h expected %h", ctrl2, {1'b1, 3'd0, 3'd0, 1'b0}); else passed++;
            end
        end
        in_re = 14'd64;
        step();
        checks++;
        if (out_idx0 !== 6'd0 || {ff0, fl0} !== 2'b10) $display("FAIL frame_wrap: got idx %0d ff/fl %b expected idx 0 ff/fl 10", out_idx0, {ff0, fl0}); else passed++;
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid0 !== 1'b0) $display("FAIL drain: got out_valid %0b expected 0", out_valid0); else passed++;
    endtask

    task automatic test_data();
        in_valid = 1'b1;
        in_re = 14'h2000;
        in_im = 14'h1FFF;
        step();
        checks++;
        if (out_re0 !== 14'h2000 || out_im0 !== 14'h1FFF) $display("FAIL data_pass: got re %h im %h expected re 2000 im 1fff", out_re0, out_im0); else passed++;
        checks++;
        if (out_idx0 !== 6'd1 || ctrl0 !== {1'b1, 3'd0, 3'd0, 1'b0}) $display("FAIL data_ctrl: got idx %0d ctrl %h expected idx 1 ctrl 80", out_idx0, ctrl0); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_re     = 14'd100;
        step();
        checks++;
        if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_re0 !== 14'd100 || out_idx0 !== 6'd2)
            $display("FAIL bp_load: got v %0b rdy %0b re %0d idx %0d expected v 1 rdy 0 re 100 idx 2", out_valid0, in_ready0, out_re0, out_idx0);
        else passed++;
        in_re = 14'd101;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_re0 !== 14'd100 || out_idx0 !== 6'd2)
                $display("FAIL bp_hold_%0d: got rdy %0b v %0b re %0d idx %0d expected rdy 0 v 1 re 100 idx 2", c, in_ready0, out_valid0, out_re0, out_idx0);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) $display("FAIL bp_ready_comb: got %0b expected 1", in_ready0); else passed++;
        step();
        checks++;
        if (out_re0 !== 14'd101 || out_idx0 !== 6'd3 || out_valid0 !== 1'b1) $display("FAIL bp_release1: got re %0d idx %0d expected re 101 idx 3", out_re0, out_idx0); else passed++;
        in_re = 14'd102;
        step();
        checks++;
        if (out_re0 !== 14'd102 || out_idx0 !== 6'd4 || out_valid0 !== 1'b1) $display("FAIL bp_release2: got re %0d idx %0d expected re 102 idx 4", out_re0, out_idx0); else passed++;
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid0 !== 1'b0) $display("FAIL bp_no_dup: got out_valid %0b expected 0", out_valid0); else passed++;
    endtask

    task automatic test_frame_clr();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        in_valid  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_re = W'(n);
            step();
        end
        frame_clr = 1'b1;
        in_re = 14'd20;
        step();
        checks++;
        if (out_idx0 !== 6'd20) $display("FAIL clr_same_cycle: got idx %0d expected 20", out_idx0); else passed++;
        frame_clr = 1'b0;
        step();
        checks++;
        if (out_idx0 !== 6'd0 || ff0 !== 1'b1) $display("FAIL clr_next: got idx %0d ff %0b expected idx 0 ff 1", out_idx0, ff0); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        in_valid  = 1'b1;
        for (int n = 0; n < 38; n++) begin
            in_re = W'(n);
            step();
        end
        checks++;
        if (out_idx0 !== 6'd37 || out_valid0 !== 1'b1) $display("FAIL ares_pre: got idx %0d v %0b expected idx 37 v 1", out_idx0, out_valid0); else passed++;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL ares_immediate: got v %0b rdy %0b expected v 0 rdy 1", out_valid0, in_ready0); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_re = 14'd55;
        step();
        checks++;
        if (out_idx0 !== 6'd0 || out_valid0 !== 1'b1 || out_re0 !== 14'd55) $display("FAIL ares_restart: got idx %0d v %0b re %0d expected idx 0 v 1 re 55", out_idx0, out_valid0, out_re0); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stage_frame();
        test_data();
        test_backpressure();
        test_frame_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
